// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding, counter widths and saturating helpers for the key bank
package key_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } key_state_t;

  localparam int DB_CNT_W   = 8;
  localparam int HOLD_CNT_W = 16;

  function automatic logic [DB_CNT_W-1:0] db_inc(input logic [DB_CNT_W-1:0] c);
    return (c == '1) ? c : c + DB_CNT_W'(1);
  endfunction

  function automatic logic [HOLD_CNT_W-1:0] hold_inc(input logic [HOLD_CNT_W-1:0] c);
    return (c == '1) ? c : c + HOLD_CNT_W'(1);
  endfunction

endpackage

// File: rtl/key_db_chan.sv
// rtl/key_db_chan.sv - one key channel: 2-flop synchronizer, debounce FSM, optional hold/repeat (KEY_AUTOREPEAT_EN)
module key_db_chan
  import key_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int ACTIVE_LOW  = 1,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic ms_tick,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam logic IDLE_LEVEL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [DB_CNT_W-1:0] DB_TARGET = DB_CNT_W'(DEBOUNCE_MS);

  logic                sync_q1;
  logic                sync_q2;
  logic                level;
  key_state_t          state;
  logic [DB_CNT_W-1:0] db_cnt;
  logic [DB_CNT_W-1:0] db_cnt_next;

  // Synchronizer resets to the idle pin level so reset release never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= IDLE_LEVEL;
      sync_q2 <= IDLE_LEVEL;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  assign level       = sync_q2 ^ IDLE_LEVEL;
  assign db_cnt_next = ms_tick ? db_inc(db_cnt) : db_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_RELEASED;
      db_cnt        <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        ST_RELEASED: begin
          if (level) begin
            state  <= ST_PRESS_CHK;
            db_cnt <= '0;
          end
        end
        ST_PRESS_CHK: begin
          if (!level) begin
            state <= ST_RELEASED;
          end else if (db_cnt_next == DB_TARGET) begin
            state       <= ST_PRESSED;
            db_cnt      <= '0;
            pressed     <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            db_cnt <= db_cnt_next;
          end
        end
        ST_PRESSED: begin
          if (!level) begin
            state  <= ST_RELEASE_CHK;
            db_cnt <= '0;
          end
        end
        ST_RELEASE_CHK: begin
          if (level) begin
            state <= ST_PRESSED;
          end else if (db_cnt_next == DB_TARGET) begin
            state         <= ST_RELEASED;
            db_cnt        <= '0;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            db_cnt <= db_cnt_next;
          end
        end
        default: begin
          state  <= ST_RELEASED;
          db_cnt <= '0;
        end
      endcase
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_TARGET = HOLD_CNT_W'(HOLD_MS);
  localparam logic [HOLD_CNT_W-1:0] HOLD_RELOAD = HOLD_CNT_W'(HOLD_MS - REPEAT_MS);

  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic [HOLD_CNT_W-1:0] hold_cnt_next;

  assign hold_cnt_next = ms_tick ? hold_inc(hold_cnt) : hold_cnt;

  // After the first strobe the counter is rewound by REPEAT_MS so later strobes reuse the same compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt     <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (state != ST_PRESSED) begin
        hold_cnt <= '0;
      end else if (ms_tick && (hold_cnt_next == HOLD_TARGET)) begin
        hold_cnt     <= HOLD_RELOAD;
        repeat_pulse <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt_next;
      end
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_bank_debounce.sv
// rtl/key_bank_debounce.sv - N-key debounce bank with shared 1 ms prescaler; auto-repeat under KEY_AUTOREPEAT_EN
module key_bank_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS      = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int ACTIVE_LOW  = 1,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] repeat_pulse,
  output logic              key_any
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             ms_tick;

  assign ms_tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (ms_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_db_chan #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .ACTIVE_LOW  (ACTIVE_LOW),
      .HOLD_MS     (HOLD_MS),
      .REPEAT_MS   (REPEAT_MS)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .raw           (key_raw[i]),
      .ms_tick       (ms_tick),
      .pressed       (key_pressed[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

  assign key_any = |key_pressed;

endmodule

// File: doc/key_bank_debounce.md
KEY_BANK_DEBOUNCE -- requirements
Module: key_bank_debounce

Interface
REQ-001 SHALL have parameter N_KEYS, default 4: number of independent key channels, range 1..16.
REQ-002 SHALL have parameter CLK_HZ, default 50_000_000: clk frequency in Hz.
REQ-003 SHALL have parameter DEBOUNCE_MS, default 20: stable time required to accept a change, range 1..255.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 means raw 0 = pressed; 0 means raw 1 = pressed.
REQ-005 SHALL have parameters HOLD_MS, default 500, and REPEAT_MS, default 100, used only under KEY_AUTOREPEAT_EN.
REQ-006 SHALL have port clk, input, 1 bit: system clock; the block uses one clock only.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port key_raw, input, N_KEYS bits: asynchronous raw key pins.
REQ-009 SHALL have port key_pressed, output, N_KEYS bits: debounced level, 1 = pressed, independent of ACTIVE_LOW.
REQ-010 SHALL have port press_pulse, output, N_KEYS bits: one-cycle high when key_pressed rises.
REQ-011 SHALL have port release_pulse, output, N_KEYS bits: one-cycle high when key_pressed falls.
REQ-012 SHALL have port repeat_pulse, output, N_KEYS bits: one-cycle auto-repeat strobe.
REQ-013 SHALL have port key_any, output, 1 bit: OR of key_pressed.

Function
REQ-014 SHALL pass each key_raw bit through a 2-flop synchronizer, then normalize it to pressed = 1 per ACTIVE_LOW.
REQ-015 SHALL generate one shared ms_tick: a one-cycle pulse every CLK_HZ/1000 cycles from a free-running prescaler, with width $clog2(CLK_HZ/1000).
REQ-016 SHALL give each channel a 4-state FSM: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK.
REQ-017 SHALL move RELEASED to PRESS_CHK when the synchronized level is 1, clearing the channel counter.
REQ-018 SHALL, in PRESS_CHK, go back to RELEASED on level 0 with no pulse, and otherwise increment the 8-bit counter on each ms_tick.
REQ-019 SHALL, in PRESS_CHK, move to PRESSED when counter == DEBOUNCE_MS; on that edge key_pressed goes to 1 and press_pulse fires in the same cycle.
REQ-020 SHALL make PRESSED to RELEASE_CHK to RELEASED the mirror image of REQ-017 to REQ-019, producing release_pulse.
REQ-021 SHALL accept a change after DEBOUNCE_MS ms minus at most 1 ms of tick phase, plus 2 cycles of synchronizer latency.
REQ-022 SHALL treat channels independently; several pulses in the same cycle are legal.
REQ-023 SHALL register press_pulse, release_pulse and repeat_pulse; press and release for one channel are never high together.
REQ-024 SHALL derive key_any combinationally from key_pressed.
REQ-025 SHALL saturate counters and never wrap.

Reset
REQ-026 SHALL, on rst_n low: put every FSM in RELEASED, clear all counters and the prescaler, load synchronizer flops with the released level, and drive all outputs to 0.
REQ-027 SHALL, when reset is asserted mid-debounce or mid-hold, abort with no pulse; a key held through reset release produces press_pulse after a full debounce.

Configuration
REQ-028 SHALL, when KEY_AUTOREPEAT_EN is defined, give each channel a 16-bit hold counter that counts ms_tick while in PRESSED.
REQ-029 SHALL, with KEY_AUTOREPEAT_EN defined, fire repeat_pulse at HOLD_MS, then every REPEAT_MS, and clear the hold counter on leaving PRESSED.
REQ-030 SHALL, without KEY_AUTOREPEAT_EN, tie repeat_pulse to 0 and include no hold logic.

Structure
REQ-031 SHALL define the FSM state enum and the counter width constants in the shared package key_pkg.
REQ-032 SHALL implement one sub-module, key_db_chan (synchronizer, FSM, counters), instantiated N_KEYS times in a generate loop; the prescaler lives in the top level.

Verification
Bench parameters: CLK_HZ=10_000 (10 cycles per ms), DEBOUNCE_MS=4, N_KEYS=4, ACTIVE_LOW=1.
REQ-033 SHALL cover: key_raw[0]=0 held for 60 cycles -> key_pressed[0]=1 within 32..42 cycles, exactly one press_pulse[0].
REQ-034 SHALL cover: key_raw[1] toggling every 15 cycles for 200 cycles -> no pulses and key_pressed[1] stays 0.
REQ-035 SHALL cover: keys 2 and 3 pressed in the same cycle -> both press_pulse bits high in the same cycle, key_any=1; both released -> two release_pulse bits high, key_any=0.
REQ-036 SHALL cover: rst_n pulsed low while key 0 is in PRESS_CHK -> outputs 0, no pulse; key still held -> press_pulse after 4 ms.
REQ-037 SHALL cover: with KEY_AUTOREPEAT_EN, HOLD_MS=10, REPEAT_MS=3, key held 200 cycles -> repeat_pulse at about 100 cycles after press, then every 30 cycles; without the macro -> repeat_pulse always 0.
